alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Sequencer that shares the single combinational ALU between two requesters (req0: execute stage, req1: address/aux unit). Arbitrates with valid/ready, registers the winning operation, drives the ALU for one issue cycle, captures the result, and derives Z/N/V flags locally. Returns the result on a per-requester response channel held until accepted.

Parameters:
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (req0 always wins ties)
RST_LAST, 1, reset value of the last-grant pointer; 1 means req0 wins the first tie after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  req0 operation present
req0_ready  out  1  req0 operation accepted this cycle
req0_op  in  3  ALU opcode (001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT)
req0_a  in  32  operand A
req0_b  in  32  operand B (ignored for NOT)
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as req0
resp0_valid  out  1  response for req0 available
resp0_ready  in  1  req0 consumes response
resp1_valid  out  1  response for req1 available
resp1_ready  in  1  req1 consumes response
resp_data  out  32  result (shared by both response channels)
resp_zero  out  1  resp_data == 0
resp_neg  out  1  resp_data[31]
resp_ovf  out  1  signed overflow (ADD/SUB only, else 0)
resp_err  out  1  opcode was 000 or 111
busy  out  1  state != IDLE
alu_opcode  out  3  to ALU opcode
alu_operand1  out  33  to ALU operand1, {1'b0, A}
alu_operand2  out  33  to ALU operand2, {1'b0, B}
alu_res_out  in  32  from ALU result

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high. Asserting rst forces IDLE immediately; all outputs go to 0, last-grant = RST_LAST, and any in-flight operation is dropped (the requester reissues).
- States: IDLE -> ISSUE -> RESP -> IDLE. Encoded 2 bits.
- IDLE: grant is combinational from the valids. Single valid: grant it. Both valid: ARB_MODE=1 grants req0. ARB_MODE=0 grants the requester not in last-grant. reqN_ready = (state==IDLE) & grantN; at most one ready per cycle. On handshake, latch op/a/b/owner, update last-grant, and go to ISSUE.
- Requesters hold valid and payload stable until ready. They do not withdraw valid.
- ISSUE (1 cycle): drive alu_opcode = latched op and operands = {1'b0,a}/{1'b0,b}. At the clock edge, capture alu_res_out into resp_data and register the flags. Go to RESP.
- Invalid op (000/111): alu_opcode stays 000. resp_data = 0, resp_err = 1, resp_zero = 1, other flags 0.
- Outside ISSUE, alu_opcode = 000 and operands = 0.
- resp_ovf:
  - ADD: a[31]==b[31] && r[31]!=a[31].
  - SUB: a[31]!=b[31] && r[31]!=a[31].
  - Otherwise 0.
  - The ALU's own overflow output is not used.
- RESP: assert respN_valid for the owner only. resp_data and flags are held stable until respN_ready; on that handshake go to IDLE. The other channel's ready is ignored. No new request is accepted in RESP.
- Latency: request handshake at cycle 0, resp_valid at cycle 2. Peak throughput is one operation per 3 cycles when resp_ready is tied high.
- resp_data and flags keep their last value in IDLE; valid is the only qualifier.

Decomposition:
- Shared include alu_ctrl_defs.vh: opcode constants (ADD..NOT, NOP=000) and state encodings IDLE/ISSUE/RESP, also used by the ALU and decode.
- Sub-module alu_rr_arbiter: 2-way combinational grant plus registered last-grant pointer, with ARB_MODE and RST_LAST parameters.
- FSM, capture registers and flag logic stay in alu_share_ctrl.

Test Plan:
- Single ADD: req0 ADD a=5 b=7 -> req0_ready at cycle 0, alu_opcode=001 in cycle 1, resp0_valid at cycle 2 with data=12, zero=0, neg=0, ovf=0, err=0.
- SUB to zero and overflow: req1 SUB 3-3 -> data=0, zero=1. Then req1 ADD 0x7FFFFFFF+1 -> data=0x80000000, neg=1, ovf=1.
- Contention, ARB_MODE=0: both valid continuously from reset -> grants req0, req1, req0, req1; each response goes to the correct channel only. With ARB_MODE=1 -> req0 every time.
- Invalid opcode: req0 op=111 -> alu_opcode stays 000, resp_data=0, err=1, zero=1.
- Backpressure: resp0_ready low for 4 cycles with req1_valid high -> resp0_valid, data and flags stable; req1_ready=0 throughout. Release -> IDLE, then req1 granted next cycle.
- Reset mid-op: assert rst during ISSUE -> busy, resp*_valid and alu_opcode go to 0 without waiting for a clock edge. After release, a tie grants req0 (RST_LAST=1).

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and flag helpers for the
// shared-ALU sequencer and anything that decodes the same opcode space.
package alu_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_BAD = 3'b111;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_BAD);
    endfunction

    // Signed overflow from operand and result sign bits only; the ALU's own
    // overflow output is deliberately not consulted.
    function automatic logic calc_ovf(input logic [2:0] op, input logic a_s,
                                      input logic b_s, input logic r_s);
        logic ovf;
        ovf = 1'b0;
        if (op == OP_ADD)
            ovf = (a_s == b_s) && (r_s != a_s);
        else if (op == OP_SUB)
            ovf = (a_s != b_s) && (r_s != a_s);
        return ovf;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request, response and ALU-side signals of the shared-ALU sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
// the source holds valid and payload stable until then and never withdraws valid.
interface alu_share_ctrl_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp0_valid;
    logic        resp0_ready;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp_data;
    logic        resp_zero;
    logic        resp_neg;
    logic        resp_ovf;
    logic        resp_err;
    logic        busy;
    logic [2:0]  alu_opcode;
    logic [32:0] alu_operand1;
    logic [32:0] alu_operand2;
    logic [31:0] alu_res_out;

    // master: requesters plus the combinational ALU; slave: the sequencer
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready, alu_res_out,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_data, resp_zero, resp_neg, resp_ovf, resp_err,
        input  busy, alu_opcode, alu_operand1, alu_operand2
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready, alu_res_out,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_data, resp_zero, resp_neg, resp_ovf, resp_err,
        output busy, alu_opcode, alu_operand1, alu_operand2
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Two-way combinational grant with a registered last-grant pointer.
// last_q = 1 means req1 won most recently, so req0 wins the next tie in round-robin mode.
module alu_rr_arbiter #(
    parameter int ARB_MODE = 0,
    parameter bit RST_LAST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant0,
    output logic grant1
);

    logic last_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (valid0 && valid1) begin
            if (ARB_MODE == 1 || last_q)
                grant0 = 1'b1;
            else
                grant1 = 1'b1;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= RST_LAST;
        else if (advance)
            last_q <= grant1;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: arbitrate, issue for one
// cycle, capture the result with locally derived flags, and hold it until accepted.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter bit RST_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_ctrl_if.slave  bus,
    output state_t           dbg_state
);

    state_t      state;
    logic        owner_q;
    logic [2:0]  op_q;
    logic        a_sign_q;
    logic        b_sign_q;
    logic        grant0;
    logic        grant1;
    logic        fire;
    logic [2:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        resp_take;

    alu_rr_arbiter #(
        .ARB_MODE (ARB_MODE),
        .RST_LAST (RST_LAST)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid0  (bus.req0_valid),
        .valid1  (bus.req1_valid),
        .advance (fire),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    assign fire           = (state == ST_IDLE) && (grant0 || grant1);
    assign bus.req0_ready = (state == ST_IDLE) && grant0;
    assign bus.req1_ready = (state == ST_IDLE) && grant1;
    assign sel_op         = grant1 ? bus.req1_op : bus.req0_op;
    assign sel_a          = grant1 ? bus.req1_a  : bus.req0_a;
    assign sel_b          = grant1 ? bus.req1_b  : bus.req0_b;
    assign resp_take      = owner_q ? bus.resp1_ready : bus.resp0_ready;
    assign dbg_state      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            owner_q          <= 1'b0;
            op_q             <= OP_NOP;
            a_sign_q         <= 1'b0;
            b_sign_q         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.alu_opcode   <= OP_NOP;
            bus.alu_operand1 <= '0;
            bus.alu_operand2 <= '0;
            bus.resp0_valid  <= 1'b0;
            bus.resp1_valid  <= 1'b0;
            bus.resp_data    <= '0;
            bus.resp_zero    <= 1'b0;
            bus.resp_neg     <= 1'b0;
            bus.resp_ovf     <= 1'b0;
            bus.resp_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        owner_q  <= grant1;
                        op_q     <= sel_op;
                        a_sign_q <= sel_a[31];
                        b_sign_q <= sel_b[31];
                        bus.busy <= 1'b1;
                        // Invalid opcodes never reach the ALU; it sees a quiet NOP.
                        if (op_is_valid(sel_op)) begin
                            bus.alu_opcode   <= sel_op;
                            bus.alu_operand1 <= {1'b0, sel_a};
                            bus.alu_operand2 <= {1'b0, sel_b};
                        end
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    bus.alu_opcode   <= OP_NOP;
                    bus.alu_operand1 <= '0;
                    bus.alu_operand2 <= '0;
                    if (op_is_valid(op_q)) begin
                        bus.resp_data <= bus.alu_res_out;
                        bus.resp_zero <= (bus.alu_res_out == 32'd0);
                        bus.resp_neg  <= bus.alu_res_out[31];
                        bus.resp_ovf  <= calc_ovf(op_q, a_sign_q, b_sign_q,
                                                  bus.alu_res_out[31]);
                        bus.resp_err  <= 1'b0;
                    end else begin
                        bus.resp_data <= '0;
                        bus.resp_zero <= 1'b1;
                        bus.resp_neg  <= 1'b0;
                        bus.resp_ovf  <= 1'b0;
                        bus.resp_err  <= 1'b1;
                    end
                    bus.resp0_valid <= ~owner_q;
                    bus.resp1_valid <= owner_q;
                    state           <= ST_RESP;
                end

                ST_RESP: begin
                    // Only the owner's ready completes the response.
                    if (resp_take) begin
                        bus.resp0_valid <= 1'b0;
                        bus.resp1_valid <= 1'b0;
                        bus.busy        <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end

                default: begin
                    bus.resp0_valid <= 1'b0;
                    bus.resp1_valid <= 1'b0;
                    bus.busy        <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a round-robin instance checked in detail and a
// fixed-priority instance fed the same requests, checked under contention.
module tb_alu_share_ctrl;
    import alu_share_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    state_t st;
    state_t st_fp;

    always #5 clk = ~clk;

    alu_share_ctrl_if bus();
    alu_share_ctrl_if bus_fp();

    alu_share_ctrl #(.ARB_MODE(0), .RST_LAST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(st)
    );

    alu_share_ctrl #(.ARB_MODE(1), .RST_LAST(1'b1)) u_fp (
        .clk(clk), .rst(rst), .bus(bus_fp), .dbg_state(st_fp)
    );

    function automatic logic [31:0] alu_model(input logic [2:0] op,
                                              input logic [32:0] x,
                                              input logic [32:0] y);
        logic [32:0] r;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NOT:  r = ~x;
            default: r = '0;
        endcase
        return r[31:0];
    endfunction

    always_comb bus.alu_res_out = alu_model(bus.alu_opcode, bus.alu_operand1, bus.alu_operand2);
    always_comb bus_fp.alu_res_out = alu_model(bus_fp.alu_opcode, bus_fp.alu_operand1, bus_fp.alu_operand2);

    assign bus_fp.req0_valid  = bus.req0_valid;
    assign bus_fp.req0_op     = bus.req0_op;
    assign bus_fp.req0_a      = bus.req0_a;
    assign bus_fp.req0_b      = bus.req0_b;
    assign bus_fp.req1_valid  = bus.req1_valid;
    assign bus_fp.req1_op     = bus.req1_op;
    assign bus_fp.req1_a      = bus.req1_a;
    assign bus_fp.req1_b      = bus.req1_b;
    assign bus_fp.resp0_ready = bus.resp0_ready;
    assign bus_fp.resp1_ready = bus.resp1_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (st != ST_IDLE && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, st, ST_IDLE);
    endtask

    // One complete transaction on channel `who`; flags are {zero,neg,ovf,err}.
    task automatic run_op(input int who, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] exp_aop,
                          input logic [31:0] exp_d, input logic [3:0] exp_f,
                          input string tag);
        wait_idle(tag);
        if (who == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
        #1;
        chk({tag, "_rdy0"}, bus.req0_ready, (who == 0));
        chk({tag, "_rdy1"}, bus.req1_ready, (who == 1));
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk({tag, "_st_issue"}, st, ST_ISSUE);
        chk({tag, "_aluop"}, bus.alu_opcode, exp_aop);
        chk({tag, "_opnd1"}, bus.alu_operand1, (exp_aop == 3'd0) ? 33'd0 : {1'b0, a});
        chk({tag, "_busy"}, bus.busy, 1'b1);
        tick();
        chk({tag, "_v0"}, bus.resp0_valid, (who == 0));
        chk({tag, "_v1"}, bus.resp1_valid, (who == 1));
        chk({tag, "_data"}, bus.resp_data, exp_d);
        chk({tag, "_flags"}, {bus.resp_zero, bus.resp_neg, bus.resp_ovf, bus.resp_err}, exp_f);
        chk({tag, "_aluop_off"}, bus.alu_opcode, 3'd0);
        if (who == 0) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
        tick();
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        chk({tag, "_done"}, st, ST_IDLE);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired before test end");
        $fatal(1, "timeout");
    end

    initial begin
        int own_seq[4];
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
        #12;
        chk("rst_state", st, ST_IDLE);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_v", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
        chk("rst_aluop", bus.alu_opcode, 3'd0);
        chk("rst_data", bus.resp_data, 32'd0);
        chk("rst_flags", {bus.resp_zero, bus.resp_neg, bus.resp_ovf, bus.resp_err}, 4'b0000);
        rst = 1'b0;
        tick();

        run_op(0, OP_ADD, 32'd5, 32'd7, 3'd1, 32'd12, 4'b0000, "add");
        run_op(1, OP_SUB, 32'd3, 32'd3, 3'd2, 32'd0, 4'b1000, "sub0");
        run_op(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 3'd1, 32'h8000_0000, 4'b0110, "addovf");
        run_op(0, OP_BAD, 32'd1, 32'd2, 3'd0, 32'd0, 4'b1001, "inv7");
        run_op(1, OP_NOP, 32'd9, 32'd9, 3'd0, 32'd0, 4'b1001, "inv0");
        run_op(0, OP_SUB, 32'h8000_0000, 32'd1, 3'd2, 32'h7FFF_FFFF, 4'b0010, "subovf");
        run_op(1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 3'd3, 32'h0000_F000, 4'b0000, "and");
        run_op(0, OP_OR, 32'h0000_F0F0, 32'h0000_0F0F, 3'd4, 32'h0000_FFFF, 4'b0000, "or");
        run_op(1, OP_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 32'd0, 4'b1000, "xor");
        run_op(0, OP_NOT, 32'd0, 32'h1234, 3'd6, 32'hFFFF_FFFF, 4'b0100, "not");
        run_op(1, OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'hFFFF_FFFE, 4'b0100, "addneg");

        // Backpressure on resp0 while req1 waits; resp1_ready high must be ignored.
        wait_idle("bp");
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd2; bus.req0_b = 32'd3;
        #1;
        chk("bp_rdy0", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 32'd9; bus.req1_b = 32'd2;
        bus.resp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_v0", bus.resp0_valid, 1'b1);
            chk("bp_v1", bus.resp1_valid, 1'b0);
            chk("bp_data", bus.resp_data, 32'd5);
            chk("bp_flags", {bus.resp_zero, bus.resp_neg, bus.resp_ovf, bus.resp_err}, 4'b0000);
            chk("bp_rdy1", bus.req1_ready, 1'b0);
            tick();
        end
        bus.resp0_ready = 1'b1;
        tick();
        bus.resp0_ready = 1'b0;
        chk("bp_idle", st, ST_IDLE);
        chk("bp_rdy1_after", bus.req1_ready, 1'b1);
        tick();
        bus.req1_valid = 1'b0;
        chk("bp_issue1", st, ST_ISSUE);
        tick();
        chk("bp_v1_resp", bus.resp1_valid, 1'b1);
        chk("bp_data1", bus.resp_data, 32'd7);
        tick();
        bus.resp1_ready = 1'b0;
        chk("bp_end", st, ST_IDLE);

        // Asynchronous reset while an operation is in ISSUE.
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        tick();
        bus.req0_valid = 1'b0;
        chk("rmid_issue", st, ST_ISSUE);
        chk("rmid_aluop", bus.alu_opcode, 3'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmid_busy", bus.busy, 1'b0);
        chk("rmid_aluop0", bus.alu_opcode, 3'd0);
        chk("rmid_state", st, ST_IDLE);
        chk("rmid_v", {bus.resp0_valid, bus.resp1_valid}, 2'b00);
        chk("rmid_fp_state", st_fp, ST_IDLE);
        #2;
        rst = 1'b0;

        // Continuous contention: round-robin alternates, fixed priority always req0.
        bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd1;  bus.req0_b = 32'd1;
        bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 32'd10; bus.req1_b = 32'd4;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        #1;
        own_seq = '{0, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            chk("ct_idle", st, ST_IDLE);
            chk("ct_rdy0", bus.req0_ready, (own_seq[k] == 0));
            chk("ct_rdy1", bus.req1_ready, (own_seq[k] == 1));
            chk("ct_fp_rdy", {bus_fp.req0_ready, bus_fp.req1_ready}, 2'b10);
            tick();
            tick();
            chk("ct_v0", bus.resp0_valid, (own_seq[k] == 0));
            chk("ct_v1", bus.resp1_valid, (own_seq[k] == 1));
            chk("ct_data", bus.resp_data, (own_seq[k] == 1) ? 32'd6 : 32'd2);
            chk("ct_fp_v", {bus_fp.resp0_valid, bus_fp.resp1_valid}, 2'b10);
            chk("ct_fp_data", bus_fp.resp_data, 32'd2);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("end_idle", st, ST_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
